// File: rtl/free_list_mp.sv
// free_list_mp -- multi-port physical register free list for the rename stage.
//
// Tracks which physical registers are free with a bitmap (1 = free, 0 = in use).
// Up to ALLOC_W registers are handed out per cycle, always as a complete group
// and never partially. Up to FREE_W registers are returned per cycle.
// CKPT_DEPTH snapshots of the bitmap are kept so that a mispredicted branch can
// give back the registers taken by the younger, squashed ops.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        synchronous, active-low reset
//   alloc_req    per-lane allocation request
//   alloc_ready  at least ALLOC_W registers are free and no restore is in progress
//   alloc_phys   lane i grant in [i*PW +: PW]; zero when alloc_ready is low
//   free_en      per-lane release strobe
//   free_phys    lane j register to release in [j*PW +: PW]
//   ckpt_en      take a snapshot into slot ckpt_id
//   ckpt_id      snapshot slot to write
//   restore_en   mispredict: merge slot restore_id back into the free bitmap
//   restore_id   snapshot slot to read
//   free_count   registered population count of the free bitmap
//   dbl_free_err sticky flag for an illegal release
module free_list_mp #(
  parameter int PREGS      = 64,
  parameter int ARCH_REGS  = 32,
  parameter int ALLOC_W    = 2,
  parameter int FREE_W     = 2,
  parameter int CKPT_DEPTH = 4,
  localparam int PW        = $clog2(PREGS),
  localparam int CW        = $clog2(CKPT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ALLOC_W-1:0]    alloc_req,
  output logic                  alloc_ready,
  output logic [ALLOC_W*PW-1:0] alloc_phys,
  input  logic [FREE_W-1:0]     free_en,
  input  logic [FREE_W*PW-1:0]  free_phys,
  input  logic                  ckpt_en,
  input  logic [CW-1:0]         ckpt_id,
  input  logic                  restore_en,
  input  logic [CW-1:0]         restore_id,
  output logic [PW:0]           free_count,
  output logic                  dbl_free_err
);

  // Registers 0..ARCH_REGS-1 hold the initial architectural mappings.
  localparam logic [PREGS-1:0] RESET_MASK  = {{(PREGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
  localparam logic [PW:0]      RESET_COUNT = (PW+1)'(PREGS - ARCH_REGS);
  localparam logic [PW:0]      ALLOC_NEED  = (PW+1)'(ALLOC_W);

  logic [PREGS-1:0] free_mask_reg, free_mask_next;
  logic [PREGS-1:0] ckpt_reg [CKPT_DEPTH];
  logic [PW:0]      free_count_reg, free_count_next;
  logic             dbl_free_err_reg, dbl_free_err_next;

  logic [PW-1:0]    cand [ALLOC_W];
  logic [PREGS-1:0] alloc_clr;
  logic [PREGS-1:0] free_set;
  logic             free_err;
  logic [FREE_W-1:0] phys_oob;

  // A restore rewrites the bitmap this cycle, so grants are withheld.
  assign alloc_ready = (free_count_reg >= ALLOC_NEED) && !restore_en;

  // Lane i takes the i-th lowest free register: each lane searches the bitmap
  // with the picks of the lower lanes already removed. The candidate is
  // computed for every lane, but only requested lanes actually consume it.
  always_comb begin
    logic [PREGS-1:0] search_mask;
    logic             found;
    search_mask = free_mask_reg;
    alloc_clr   = '0;
    found       = 1'b0;
    for (int i = 0; i < ALLOC_W; i++) begin
      cand[i] = '0;
      found   = 1'b0;
      for (int b = 0; b < PREGS; b++) begin
        if (search_mask[b] && !found) begin
          cand[i] = PW'(b);
          found   = 1'b1;
        end
      end
      if (found) begin
        search_mask[cand[i]] = 1'b0;
      end
      if (alloc_req[i] && alloc_ready) begin
        alloc_clr[cand[i]] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < ALLOC_W; gi++) begin : g_alloc_lane
    assign alloc_phys[gi*PW +: PW] = alloc_ready ? cand[gi] : '0;
  end

  // Register numbers beyond the end of the file only exist when PREGS is not a
  // power of two; otherwise every encodable index is legal.
  for (genvar gi = 0; gi < FREE_W; gi++) begin : g_free_range
    if (PREGS < (1 << PW)) begin : g_check
      assign phys_oob[gi] = ({1'b0, free_phys[gi*PW +: PW]} >= (PW+1)'(PREGS));
    end else begin : g_no_check
      assign phys_oob[gi] = 1'b0;
    end
  end

  // Releases: checking against free_set as well as the bitmap catches two lanes
  // naming the same register in one cycle. The bit ends up free either way.
  always_comb begin
    free_set = '0;
    free_err = 1'b0;
    for (int j = 0; j < FREE_W; j++) begin
      if (free_en[j]) begin
        if (phys_oob[j]) begin
          free_err = 1'b1;
        end else begin
          if (free_mask_reg[free_phys[j*PW +: PW]] || free_set[free_phys[j*PW +: PW]]) begin
            free_err = 1'b1;
          end
          free_set[free_phys[j*PW +: PW]] = 1'b1;
        end
      end
    end
  end

  // alloc_clr is already empty on a restore cycle because alloc_ready is low.
  always_comb begin
    if (restore_en) begin
      free_mask_next = free_mask_reg | ckpt_reg[restore_id] | free_set;
    end else begin
      free_mask_next = (free_mask_reg & ~alloc_clr) | free_set;
    end
    free_count_next   = (PW+1)'($countones(free_mask_next));
    dbl_free_err_next = dbl_free_err_reg | free_err;
  end

  // Committed frees go into every snapshot as well. Otherwise a register freed
  // at commit, then reused by a younger op that gets squashed, would be lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      free_mask_reg    <= RESET_MASK;
      free_count_reg   <= RESET_COUNT;
      dbl_free_err_reg <= 1'b0;
      for (int k = 0; k < CKPT_DEPTH; k++) begin
        ckpt_reg[k] <= RESET_MASK;
      end
    end else begin
      free_mask_reg    <= free_mask_next;
      free_count_reg   <= free_count_next;
      dbl_free_err_reg <= dbl_free_err_next;
      for (int k = 0; k < CKPT_DEPTH; k++) begin
        // A snapshot taken alongside grants includes them: those grants go to
        // ops older than the branch.
        if (ckpt_en && !restore_en && (ckpt_id == CW'(k))) begin
          ckpt_reg[k] <= free_mask_next;
        end else begin
          ckpt_reg[k] <= ckpt_reg[k] | free_set;
        end
      end
    end
  end

  assign free_count   = free_count_reg;
  assign dbl_free_err = dbl_free_err_reg;

endmodule

// File: tb/tb_free_list_mp.sv
// tb_free_list_mp -- scoreboard bench for free_list_mp.
// The driver issues one transaction per cycle. It pushes the outputs predicted by
// a simple reference model, which holds the free list as per-register flags. A
// separate monitor pops each prediction and compares it with the DUT outputs.
module tb_free_list_mp;
  localparam int PREGS      = 64;
  localparam int ARCH_REGS  = 32;
  localparam int ALLOC_W    = 2;
  localparam int FREE_W     = 2;
  localparam int CKPT_DEPTH = 4;
  localparam int PW         = $clog2(PREGS);
  localparam int CW         = $clog2(CKPT_DEPTH);

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [ALLOC_W-1:0]    alloc_req = '0;
  logic                  alloc_ready;
  logic [ALLOC_W*PW-1:0] alloc_phys;
  logic [FREE_W-1:0]     free_en = '0;
  logic [FREE_W*PW-1:0]  free_phys = '0;
  logic                  ckpt_en = 1'b0;
  logic [CW-1:0]         ckpt_id = '0;
  logic                  restore_en = 1'b0;
  logic [CW-1:0]         restore_id = '0;
  logic [PW:0]           free_count;
  logic                  dbl_free_err;

  always #5 clk = ~clk;

  free_list_mp #(
    .PREGS(PREGS), .ARCH_REGS(ARCH_REGS), .ALLOC_W(ALLOC_W),
    .FREE_W(FREE_W), .CKPT_DEPTH(CKPT_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_phys(alloc_phys), .free_en(free_en), .free_phys(free_phys),
    .ckpt_en(ckpt_en), .ckpt_id(ckpt_id), .restore_en(restore_en),
    .restore_id(restore_id), .free_count(free_count), .dbl_free_err(dbl_free_err)
  );

  typedef struct {
    int                    id;
    logic                  ready;
    logic [ALLOC_W*PW-1:0] phys;
    logic [PW:0]           count;
    logic                  err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   txn = 0;

  // Reference model: one flag per register (1 = free) and one flag set per snapshot.
  bit m_free [PREGS];
  bit m_ck   [CKPT_DEPTH][PREGS];
  bit m_err;
  bit m_valid = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < PREGS; i++) begin
      m_free[i] = (i >= ARCH_REGS);
      for (int c = 0; c < CKPT_DEPTH; c++) m_ck[c][i] = (i >= ARCH_REGS);
    end
    m_err   = 1'b0;
    m_valid = 1'b1;
  endtask

  function automatic exp_t predict(input bit ren);
    exp_t e;
    int   cnt;
    int   n;
    int   lanes [ALLOC_W];
    cnt = 0;
    n   = 0;
    for (int l = 0; l < ALLOC_W; l++) lanes[l] = 0;
    for (int i = 0; i < PREGS; i++) begin
      if (m_free[i]) begin
        if (n < ALLOC_W) begin
          lanes[n] = i;
          n++;
        end
        cnt++;
      end
    end
    e.id    = txn;
    e.count = (PW+1)'(cnt);
    e.ready = (cnt >= ALLOC_W) && !ren;
    e.phys  = '0;
    if (e.ready) begin
      for (int l = 0; l < ALLOC_W; l++) e.phys[l*PW +: PW] = PW'(lanes[l]);
    end
    e.err = m_err;
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit [ALLOC_W-1:0] areq, input bit [FREE_W-1:0] fen,
                            input int f0, input int f1, input bit cen, input int cid,
                            input bit ren, input int rid);
    bit nf [PREGS];
    int fp [FREE_W];
    int lanes [ALLOC_W];
    int n;
    int cnt;
    bit ready;
    if (!rst) begin
      model_reset();
      return;
    end
    n   = 0;
    cnt = 0;
    for (int l = 0; l < ALLOC_W; l++) lanes[l] = 0;
    for (int i = 0; i < PREGS; i++) begin
      if (m_free[i]) begin
        if (n < ALLOC_W) begin
          lanes[n] = i;
          n++;
        end
        cnt++;
      end
    end
    ready = (cnt >= ALLOC_W) && !ren;
    for (int i = 0; i < PREGS; i++) nf[i] = ren ? (m_free[i] | m_ck[rid][i]) : m_free[i];
    if (ready) begin
      for (int l = 0; l < ALLOC_W; l++) if (areq[l]) nf[lanes[l]] = 1'b0;
    end
    fp[0] = f0;
    fp[1] = f1;
    for (int j = 0; j < FREE_W; j++) begin
      if (fen[j]) begin
        if (fp[j] >= PREGS) begin
          m_err = 1'b1;
        end else begin
          if (m_free[fp[j]]) m_err = 1'b1;
          for (int k = 0; k < j; k++) if (fen[k] && fp[k] == fp[j]) m_err = 1'b1;
          nf[fp[j]] = 1'b1;
          for (int c = 0; c < CKPT_DEPTH; c++) m_ck[c][fp[j]] = 1'b1;
        end
      end
    end
    if (cen && !ren) begin
      for (int i = 0; i < PREGS; i++) m_ck[cid][i] = nf[i];
    end
    for (int i = 0; i < PREGS; i++) m_free[i] = nf[i];
  endtask

  // One transaction = one clock cycle of inputs. The prediction uses the
  // model state from before this cycle's edge.
  task automatic drive(input bit rst, input bit [ALLOC_W-1:0] areq, input bit [FREE_W-1:0] fen,
                       input int f0, input int f1, input bit cen, input int cid,
                       input bit ren, input int rid);
    @(negedge clk);
    reset      = rst;
    alloc_req  = areq;
    free_en    = fen;
    free_phys  = {PW'(f1), PW'(f0)};
    ckpt_en    = cen;
    ckpt_id    = CW'(cid);
    restore_en = ren;
    restore_id = CW'(rid);
    if (m_valid) exp_q.push_back(predict(ren));
    model_step(rst, areq, fen, f0, f1, cen, cid, ren, rid);
    txn++;
  endtask

  task automatic idle();
    drive(1'b1, '0, '0, 0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  function automatic int pick_used();
    int idx;
    idx = $urandom_range(0, PREGS-1);
    for (int t = 0; t < 8 && m_free[idx]; t++) idx = $urandom_range(0, PREGS-1);
    return idx;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      $display("FAIL %s txn %0d: got %0h expected %0h", name, id, act, req);
    end else begin
      passes++;
    end
  endtask

  // Monitor: the DUT presents a fresh set of outputs every cycle, and these are
  // sampled mid-cycle, well away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %0d ready=%0b phys1=%0d phys0=%0d count=%0d err=%0b",
                 e.id, alloc_ready, alloc_phys[2*PW-1:PW], alloc_phys[PW-1:0], free_count, dbl_free_err);
        check("alloc_ready", e.id, 32'(alloc_ready), 32'(e.ready));
        check("alloc_phys", e.id, 32'(alloc_phys), 32'(e.phys));
        check("free_count", e.id, 32'(free_count), 32'(e.count));
        check("dbl_free_err", e.id, 32'(dbl_free_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rst_r, cen_r, ren_r;
    bit [1:0] areq_r, fen_r;
    int f0_r, f1_r;

    do_reset();
    do_reset();
    // Reset state and the first grants {33,32}.
    idle();
    // Drain the list two at a time: 32..63 in order, then empty.
    repeat (16) drive(1'b1, 2'b11, '0, 0, 0, 1'b0, 0, 1'b0, 0);
    idle();
    // Release into an empty list; the grant shows {9,5} one cycle later.
    drive(1'b1, '0, 2'b11, 5, 9, 1'b0, 0, 1'b0, 0);
    idle();
    idle();
    // Allocate with a same-cycle checkpoint, allocate again, then restore.
    do_reset();
    drive(1'b1, 2'b11, '0, 0, 0, 1'b1, 1, 1'b0, 0);
    drive(1'b1, 2'b11, '0, 0, 0, 1'b0, 0, 1'b0, 0);
    drive(1'b1, '0, '0, 0, 0, 1'b0, 0, 1'b1, 1);
    idle();
    // Free, re-allocate and restore preg 7: it must come back free.
    do_reset();
    drive(1'b1, '0, '0, 0, 0, 1'b1, 0, 1'b0, 0);
    drive(1'b1, '0, 2'b01, 7, 0, 1'b0, 0, 1'b0, 0);
    drive(1'b1, 2'b01, '0, 0, 0, 1'b0, 0, 1'b0, 0);
    drive(1'b1, '0, '0, 0, 0, 1'b0, 0, 1'b1, 0);
    idle();
    // Double releases: an already-free register, then two lanes naming the same one.
    do_reset();
    drive(1'b1, '0, 2'b01, 40, 0, 1'b0, 0, 1'b0, 0);
    idle();
    drive(1'b1, '0, 2'b11, 3, 3, 1'b0, 0, 1'b0, 0);
    idle();
    idle();
    do_reset();
    idle();

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      rst_r  = ($urandom_range(0, 99) != 0);
      areq_r = 2'($urandom_range(0, 3));
      fen_r  = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      f0_r   = pick_used();
      f1_r   = pick_used();
      if ($urandom_range(0, 7) != 0 && f1_r == f0_r) f1_r = (f0_r + 1) % PREGS;
      cen_r  = ($urandom_range(0, 5) == 0);
      ren_r  = ($urandom_range(0, 9) == 0);
      drive(rst_r, areq_r, fen_r, f0_r, f1_r, cen_r, $urandom_range(0, CKPT_DEPTH-1),
            ren_r, $urandom_range(0, CKPT_DEPTH-1));
    end
    idle();
    @(negedge clk);
    #5;
    check("scoreboard_drained", txn, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
